// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: opcode values,
// instruction field positions, fetch-state encoding and small helpers.
package fetch_pkg;

    // Opcode values carried in the top nibble of each instruction word
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_LOAD = 4'h3;
    localparam logic [3:0] OPC_HALT = 4'hF;

    // Field layout: {opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], 16'b0}
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_LSB  = 24;
    localparam int unsigned RS1_LSB = 20;
    localparam int unsigned RS2_LSB = 16;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } fetch_state_t;

    // True when an opcode nibble marks the end of the program
    function automatic logic is_halt(input logic [FIELD_W-1:0] opc);
        return opc == OPC_HALT;
    endfunction

    // Assemble an instruction word from its fields
    function automatic logic [31:0] make_instr(
        input logic [FIELD_W-1:0] opc,
        input logic [FIELD_W-1:0] rd,
        input logic [FIELD_W-1:0] rs1,
        input logic [FIELD_W-1:0] rs2
    );
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: FIELD_W] = opc;
        w[RD_LSB  +: FIELD_W] = rd;
        w[RS1_LSB +: FIELD_W] = rs1;
        w[RS2_LSB +: FIELD_W] = rs2;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO holding prefetched instruction words.
// The head word is presented on dout; dout reads zero when empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: pops on empty are ignored, pushes need space
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: loadable instruction memory, program counter,
// fetch sequencer and a prefetch queue that issues one word per cycle.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [31:0]       imem [IMEM_WORDS];
    logic [31:0]       rdata;
    logic              inflight;
    logic [CW-1:0]     count;
    logic              word_halt;
    logic              push;
    logic              pop;
    logic              has_room;
    logic              fetch_en;
    logic              issue;
    logic [ADDR_W-1:0] pc_inc;

    // Issue gating, arrival handling and PC increment
    always_comb begin
        word_halt = inflight && is_halt(rdata[OPC_MSB:OPC_LSB]);
        push      = inflight && !word_halt && !redirect_valid;
        pop       = instr_valid && instr_ready;
        has_room  = (32'(count) + 32'(inflight)) < DEPTH;
        // run is honoured on the same edge it is sampled, so an IDLE
        // sequencer issues on the edge it moves to FETCH
        fetch_en  = run && (state != ST_HALTED);
        issue     = fetch_en && has_room && !word_halt && !redirect_valid;
        pc_inc    = (pc == ADDR_W'(IMEM_WORDS - 1)) ? '0 : pc + ADDR_W'(1);
    end

    // Instruction memory: write port for loading, 1-cycle read at pc
    always_ff @(posedge clk) begin
        if (prog_we) imem[prog_addr] <= prog_data;
        rdata <= imem[pc];
    end

    // Fetch sequencer, PC, in-flight flag and halt flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            state    <= run ? ST_FETCH : ST_IDLE;
            pc       <= redirect_pc;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) pc <= pc_inc;
            if (word_halt) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE:   if (run)  state <= ST_FETCH;
                    ST_FETCH:  if (!run) state <= ST_IDLE;
                    default:   state <= ST_HALTED;
                endcase
            end
        end
    end

    // Prefetch queue; a redirect flushes it
    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (rdata),
        .dout  (instr_out),
        .count (count)
    );

    assign instr_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue.
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        run;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [5:0]  pc;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] w_add, w_sub, w_load, w_halt;
    logic [31:0] w20, w21, w62, w63, w00;
    logic [31:0] seen [$];

    instr_fetch_queue #(
        .DEPTH(4),
        .IMEM_WORDS(64),
        .ADDR_W(6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [5:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic redirect(input logic [5:0] target, input logic r, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        run            = r;
        instr_ready    = rdy;
        tick();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] bp_word(input int i);
        logic [3:0] opc;
        case (i % 4)
            0:       opc = OPC_NOP;
            1:       opc = OPC_ADD;
            2:       opc = OPC_SUB;
            default: opc = OPC_LOAD;
        endcase
        return make_instr(opc, 4'(i), 4'(i + 1), 4'(i + 9));
    endfunction

    function automatic int min4(input int v);
        return (v < 4) ? v : 4;
    endfunction

    initial begin
        w_add  = make_instr(OPC_ADD,  4'h1, 4'h2, 4'h3);
        w_sub  = make_instr(OPC_SUB,  4'h4, 4'h5, 4'h6);
        w_load = make_instr(OPC_LOAD, 4'h7, 4'h8, 4'h0);
        w_halt = make_instr(OPC_HALT, 4'h0, 4'h0, 4'h0);
        w20 = make_instr(OPC_ADD,  4'hA, 4'hB, 4'hC);
        w21 = make_instr(OPC_SUB,  4'hD, 4'hE, 4'h1);
        w62 = make_instr(OPC_LOAD, 4'h6, 4'h2, 4'h0);
        w63 = make_instr(OPC_ADD,  4'h6, 4'h3, 4'h0);
        w00 = make_instr(OPC_SUB,  4'h0, 4'h0, 4'h5);

        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // Reset asserted before any clock edge
        #2 reset = 1'b1;
        #2;
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);
        tick();
        reset = 1'b0;

        // Idle with run low: nothing issued
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(instr_valid), 0);
            check("idle_out", instr_out, 0);
            check("idle_pc", 32'(pc), 0);
        end

        // Straight-line program ending in HALT
        prog(6'd0, w_add);
        prog(6'd1, w_sub);
        prog(6'd2, w_load);
        prog(6'd3, w_halt);
        run = 1'b1; instr_ready = 1'b1;
        tick();
        check("run_pc1", 32'(pc), 1);
        check("run_nvalid", 32'(instr_valid), 0);
        tick();
        check("run_w0_valid", 32'(instr_valid), 1);
        check("run_w0", instr_out, w_add);
        tick();
        check("run_w1", instr_out, w_sub);
        tick();
        check("run_w2", instr_out, w_load);
        tick();
        check("halt_valid", 32'(instr_valid), 0);
        check("halt_out", instr_out, 0);
        check("halt_flag", 32'(halted), 1);
        check("halt_pc", 32'(pc), 4);
        tick();
        tick();
        check("halt_hold", 32'(halted), 1);
        check("halt_pc_hold", 32'(pc), 4);

        // Redirect out of HALTED clears the flag
        redirect(6'd0, 1'b0, 1'b0);
        check("redir_halted", 32'(halted), 0);
        check("redir_pc0", 32'(pc), 0);
        check("redir_valid0", 32'(instr_valid), 0);

        // Backpressure: queue fills to DEPTH and PC stalls
        for (int i = 0; i < 8; i++) prog(6'(i), bp_word(i));
        prog(6'd8, w_halt);
        run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("bp_pc", 32'(pc), 32'(min4(k)));
            check("bp_count", 32'(dut.u_fifo.count), 32'(min4(k - 1)));
        end
        check("bp_head", instr_out, bp_word(0));
        instr_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) seen.push_back(instr_out);
            else if (halted) break;
            tick();
        end
        check("bp_len", 32'(seen.size()), 8);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = (i < seen.size()) ? seen[i] : 'x;
            check("bp_word", v, bp_word(i));
        end
        check("bp_halted", 32'(halted), 1);
        check("bp_pc_end", 32'(pc), 9);

        // Redirect with a full queue
        prog(6'd20, w20);
        prog(6'd21, w21);
        prog(6'd22, w_halt);
        redirect(6'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        check("full_count", 32'(dut.u_fifo.count), 4);
        check("full_pc", 32'(pc), 4);
        redirect(6'd20, 1'b1, 1'b1);
        check("rd_valid", 32'(instr_valid), 0);
        check("rd_pc", 32'(pc), 20);
        check("rd_halted", 32'(halted), 0);
        check("rd_count", 32'(dut.u_fifo.count), 0);
        tick();
        check("rd_valid1", 32'(instr_valid), 0);
        check("rd_pc21", 32'(pc), 21);
        tick();
        check("rd_w20", instr_out, w20);
        tick();
        check("rd_w21", instr_out, w21);
        tick();
        check("rd_end_valid", 32'(instr_valid), 0);
        check("rd_end_halted", 32'(halted), 1);
        check("rd_end_pc", 32'(pc), 23);

        // PC wrap-around from 63 to 0
        prog(6'd62, w62);
        prog(6'd63, w63);
        prog(6'd0, w00);
        prog(6'd1, w_halt);
        redirect(6'd62, 1'b1, 1'b1);
        check("wr_pc62", 32'(pc), 62);
        tick();
        check("wr_pc63", 32'(pc), 63);
        tick();
        check("wr_w62", instr_out, w62);
        check("wr_pc0", 32'(pc), 0);
        tick();
        check("wr_w63", instr_out, w63);
        check("wr_pc1", 32'(pc), 1);
        tick();
        check("wr_w00", instr_out, w00);
        tick();
        check("wr_halted", 32'(halted), 1);
        check("wr_pc2", 32'(pc), 2);

        // Reset asserted mid-stream between clock edges
        redirect(6'd4, 1'b1, 1'b1);
        tick();
        tick();
        check("mr_pre_valid", 32'(instr_valid), 1);
        check("mr_pre_out", instr_out, bp_word(4));
        #2 reset = 1'b1;
        #1;
        check("mr_valid", 32'(instr_valid), 0);
        check("mr_out", instr_out, 0);
        check("mr_pc", 32'(pc), 0);
        check("mr_halted", 32'(halted), 0);
        tick();
        reset = 1'b0;
        check("mr_count", 32'(dut.u_fifo.count), 0);
        tick();
        check("mr_restart_pc", 32'(pc), 1);
        check("mr_restart_nvalid", 32'(instr_valid), 0);
        tick();
        check("mr_restart_word", instr_out, w00);
        check("mr_restart_valid", 32'(instr_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
